division_arbiter_n: RTL and testbench

Round-robin controller that shares one multi-cycle fixed-point divider (`division_n_digit` class: integer quotient plus `DIGIT`-bit fraction) between `NREQ` requesters. It latches the winning requester's operands, starts the divider, waits for completion or timeout, and returns the quotient with a one-cycle acknowledge to that requester. Divide-by-zero is trapped without using the divider. It sits between the arithmetic clients and the single divider instance in the datapath.

---
 rtl/division_arbiter_n_pkg.sv | 31 +++
 rtl/division_arbiter_n_if.sv | 35 +++
 rtl/division_arbiter_n_rr_arbiter.sv | 34 +++
 rtl/division_arbiter_n.sv | 141 ++++++++++++++
 tb/tb_division_arbiter_n.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/division_arbiter_n_pkg.sv
// Shared FSM type, timeout-counter sizing and error-pattern helper for the
// round-robin shared-divider controller.
package div_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam int TMO_DEF    = 255;
  localparam int ONES_MAX_W = 64;

  function automatic int tmo_width(input int tmo);
    return $clog2(tmo + 1);
  endfunction

  localparam int TMO_W = tmo_width(TMO_DEF);

  // Low w bits set; callers cast down to their own width.
  function automatic logic [ONES_MAX_W-1:0] err_ones(input int w);
    logic [ONES_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < ONES_MAX_W; i++) begin
      if (i < w) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/division_arbiter_n_if.sv
// Requester bus and divider-side signals of the shared-divider controller.
// slave = controller side, master = clients/divider side.
interface division_arbiter_n_if #(
  parameter int N     = 32,
  parameter int DIGIT = 16,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]   req_i;
  logic [NREQ*N-1:0] a_i;
  logic [NREQ*N-1:0] b_i;
  logic [NREQ-1:0]   ack_o;
  logic              err_o;
  logic [N-1:0]      q_int_o;
  logic [DIGIT-1:0]  q_dec_o;
  logic              busy_o;
  logic              div_start_o;
  logic              div_abort_o;
  logic [N-1:0]      div_a_o;
  logic [N-1:0]      div_b_o;
  logic              div_done_i;
  logic [N-1:0]      div_q_int_i;
  logic [DIGIT-1:0]  div_q_dec_i;

  modport slave (
    input  req_i, a_i, b_i, div_done_i, div_q_int_i, div_q_dec_i,
    output ack_o, err_o, q_int_o, q_dec_o, busy_o,
           div_start_o, div_abort_o, div_a_o, div_b_o
  );

  modport master (
    output req_i, a_i, b_i, div_done_i, div_q_int_i, div_q_dec_i,
    input  ack_o, err_o, q_int_o, q_dec_o, busy_o,
           div_start_o, div_abort_o, div_a_o, div_b_o
  );
endinterface

// File: rtl/division_arbiter_n_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping; the pointer register itself lives in the parent.
module rr_arbiter_n #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [PW-1:0]   o_idx,
  output logic            o_any
);

  logic          w_found;
  logic [PW-1:0] w_j;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = PW'((int'(i_ptr) + k) % NREQ);
      if (!w_found && i_req[w_j]) begin
        w_found    = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/division_arbiter_n.sv
// Shares one multi-cycle divider among NREQ requesters: grant, start, wait for
// done or timeout, then a one-cycle ack; divide-by-zero bypasses the divider.
module division_arbiter_n
  import div_arb_pkg::*;
#(
  parameter int N     = 32,
  parameter int DIGIT = 16,
  parameter int NREQ  = 4,
  parameter int TMO   = TMO_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  division_arbiter_n_if.slave bus
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = tmo_width(TMO);
  localparam logic [N-1:0]     Q_INT_ERR = N'(err_ones(N));
  localparam logic [DIGIT-1:0] Q_DEC_ERR = DIGIT'(err_ones(DIGIT));

  state_t           r_state;
  state_t           w_nxt;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_gnt;
  logic [NREQ-1:0]  r_gnt_oh;
  logic [CW-1:0]    r_cnt;
  logic             r_err;
  logic [N-1:0]     r_q_int;
  logic [DIGIT-1:0] r_q_dec;
  logic [N-1:0]     r_div_a;
  logic [N-1:0]     r_div_b;

  logic [NREQ-1:0]  w_gnt;
  logic [PW-1:0]    w_idx;
  logic             w_any;
  logic [N-1:0]     w_a_win;
  logic [N-1:0]     w_b_win;
  logic             w_tmo;

  rr_arbiter_n #(.NREQ(NREQ), .PW(PW)) u_rr (
    .i_req (bus.req_i),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_a_win = bus.a_i[int'(w_idx)*N +: N];
  assign w_b_win = bus.b_i[int'(w_idx)*N +: N];
  // Counter holds completed WAIT cycles, so this is the TMO-th WAIT cycle.
  assign w_tmo   = (r_cnt == CW'(TMO - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt           = r_state;
    bus.ack_o       = '0;
    bus.busy_o      = 1'b1;
    bus.div_start_o = 1'b0;
    bus.div_abort_o = 1'b0;
    case (r_state)
      IDLE: begin
        bus.busy_o = 1'b0;
        if (w_any) w_nxt = (w_b_win == '0) ? RESP : ISSUE;
      end
      ISSUE: begin
        bus.div_start_o = 1'b1;
        w_nxt           = WAIT;
      end
      WAIT: begin
        // A done landing on the timeout cycle takes priority over the abort.
        if (bus.div_done_i) begin
          w_nxt = RESP;
        end else if (w_tmo) begin
          bus.div_abort_o = 1'b1;
          w_nxt           = RESP;
        end
      end
      RESP: begin
        bus.ack_o = r_gnt_oh;
        w_nxt     = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_gnt_oh <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_q_int  <= '0;
      r_q_dec  <= '0;
      r_div_a  <= '0;
      r_div_b  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_div_a  <= w_a_win;
            r_div_b  <= w_b_win;
            r_gnt    <= w_idx;
            r_gnt_oh <= w_gnt;
            if (w_b_win == '0) begin
              r_err   <= 1'b1;
              r_q_int <= Q_INT_ERR;
              r_q_dec <= Q_DEC_ERR;
            end
          end
        end
        ISSUE: r_cnt <= '0;
        WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (bus.div_done_i) begin
            r_err   <= 1'b0;
            r_q_int <= bus.div_q_int_i;
            r_q_dec <= bus.div_q_dec_i;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_q_int <= Q_INT_ERR;
            r_q_dec <= Q_DEC_ERR;
          end
        end
        RESP: r_ptr <= (r_gnt == PW'(NREQ - 1)) ? '0 : r_gnt + PW'(1);
        default: ;
      endcase
    end
  end

  assign bus.err_o   = r_err;
  assign bus.q_int_o = r_q_int;
  assign bus.q_dec_o = r_q_dec;
  assign bus.div_a_o = r_div_a;
  assign bus.div_b_o = r_div_b;

endmodule

// File: tb/tb_division_arbiter_n.sv
// Scoreboard bench for division_arbiter_n with a latency-programmable divider model.
`timescale 1ns/1ps
module tb_division_arbiter_n;
  localparam int N = 32, DIGIT = 16, NREQ = 4, TMO = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int               idx;
    logic             err;
    logic [N-1:0]     qi;
    logic [DIGIT-1:0] qd;
    int               at;
  } exp_t;
  exp_t expq[$];

  int n_start = 0, n_abort = 0, abort_cyc = -1;
  int dm_cnt = 0, dm_lat = 4;
  bit dm_never = 1'b0;
  logic [N-1:0] dm_a = '0, dm_b = '0;

  division_arbiter_n_if #(.N(N), .DIGIT(DIGIT), .NREQ(NREQ)) bus ();

  division_arbiter_n #(.N(N), .DIGIT(DIGIT), .NREQ(NREQ), .TMO(TMO)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Divider model: done pulses L cycles after the start cycle.
  initial begin
    logic [47:0] full;
    bus.div_done_i  = 1'b0;
    bus.div_q_int_i = 32'hBAD0_0000;
    bus.div_q_dec_i = 16'hBAD0;
    forever begin
      @(posedge clk); #1;
      bus.div_done_i  = 1'b0;
      bus.div_q_int_i = 32'hBAD0_0000;
      bus.div_q_dec_i = 16'hBAD0;
      if (!rst_n) begin
        dm_cnt = 0;
      end else if (dm_cnt > 0) begin
        dm_cnt--;
        if (dm_cnt == 0 && !dm_never) begin
          full = {dm_a, 16'h0000} / {16'h0000, dm_b};
          bus.div_done_i  = 1'b1;
          bus.div_q_int_i = full[47:16];
          bus.div_q_dec_i = full[15:0];
        end
      end
    end
  end

  // Monitor: pops one expectation per ack cycle.
  initial begin
    exp_t e;
    logic [NREQ-1:0] oh;
    forever begin
      @(negedge clk);
      if (bus.div_start_o) begin
        n_start++;
        dm_cnt = dm_lat;
        dm_a   = bus.div_a_o;
        dm_b   = bus.div_b_o;
      end
      if (bus.div_abort_o) begin
        n_abort++;
        abort_cyc = cyc;
      end
      if (bus.ack_o != '0) begin
        if (expq.size() == 0) begin
          chk("unexpected_ack", 64'(bus.ack_o), 64'd0);
        end else begin
          e  = expq.pop_front();
          oh = NREQ'(1) << e.idx;
          chk("ack_onehot", 64'(bus.ack_o), 64'(oh));
          chk("ack_err",    64'(bus.err_o), 64'(e.err));
          chk("ack_q_int",  64'(bus.q_int_o), 64'(e.qi));
          chk("ack_q_dec",  64'(bus.q_dec_o), 64'(e.qd));
          chk("ack_cycle",  64'(cyc), 64'(e.at));
        end
      end
    end
  end

  task automatic set_slot(input int k, input logic [N-1:0] a, input logic [N-1:0] b);
    bus.a_i[k*N +: N] = a;
    bus.b_i[k*N +: N] = b;
  endtask

  task automatic push(input int idx, input logic err, input logic [N-1:0] qi,
                      input logic [DIGIT-1:0] qd, input int at);
    exp_t e;
    e.idx = idx; e.err = err; e.qi = qi; e.qd = qd; e.at = at;
    expq.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_acks(input int n, input int budget);
    int got   = 0;
    int spent = 0;
    while (got < n && spent < budget) begin
      tick(1);
      spent++;
      if (bus.ack_o != '0) got++;
    end
    if (got < n) chk("ack_wait_budget", 64'(got), 64'(n));
  endtask

  initial begin
    int t, s0, a0;
    int order [6];
    logic [N-1:0]     sq_i [NREQ];
    logic [DIGIT-1:0] sq_d [NREQ];
    order = '{0, 1, 3, 0, 1, 3};
    sq_i = '{32'd14, 32'd0, 32'd0, 32'd7};
    sq_d = '{16'h4924, 16'h8000, 16'h0000, 16'h0000};

    bus.req_i = '0;
    bus.a_i   = '0;
    bus.b_i   = '0;

    // Reset state
    #13;
    chk("rst_busy",  64'(bus.busy_o), 64'd0);
    chk("rst_ack",   64'(bus.ack_o), 64'd0);
    chk("rst_start", 64'(bus.div_start_o), 64'd0);
    chk("rst_abort", 64'(bus.div_abort_o), 64'd0);
    chk("rst_err",   64'(bus.err_o), 64'd0);
    chk("rst_q_int", 64'(bus.q_int_o), 64'd0);
    chk("rst_q_dec", 64'(bus.q_dec_o), 64'd0);
    chk("rst_div_a", 64'(bus.div_a_o), 64'd0);
    chk("rst_div_b", 64'(bus.div_b_o), 64'd0);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Single request, L=50
    set_slot(0, 32'd100, 32'd7);
    dm_lat = 50;
    s0 = n_start;
    bus.req_i = 4'b0001;
    t = cyc;
    push(0, 1'b0, 32'd14, 16'h4924, t + 52);
    wait_acks(1, 100);
    tick(1);
    bus.req_i = '0;
    chk("single_starts", 64'(n_start - s0), 64'd1);
    tick(3);
    chk("q_int_held", 64'(bus.q_int_o), 64'd14);

    // Contention from reset: 0,1,3 continuously
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    set_slot(1, 32'd1, 32'd2);
    set_slot(3, 32'd7, 32'd1);
    dm_lat = 4;
    s0 = n_start;
    bus.req_i = 4'b1011;
    t = cyc;
    for (int k = 0; k < 6; k++) push(order[k], 1'b0, sq_i[order[k]], sq_d[order[k]], t + 6 + 7*k);
    wait_acks(6, 100);
    tick(1);
    bus.req_i = '0;
    chk("contention_starts", 64'(n_start - s0), 64'd6);

    // Divide-by-zero
    tick(2);
    set_slot(2, 32'd5, 32'd0);
    s0 = n_start;
    bus.req_i = 4'b0100;
    t = cyc;
    push(2, 1'b1, '1, '1, t + 1);
    wait_acks(1, 20);
    tick(1);
    bus.req_i = '0;
    chk("dz_no_start", 64'(n_start - s0), 64'd0);

    // Timeout, then slot 2 (raised during WAIT) served normally
    tick(2);
    set_slot(1, 32'd9, 32'd3);
    dm_never = 1'b1;
    s0 = n_start;
    a0 = n_abort;
    bus.req_i = 4'b0010;
    t = cyc;
    push(1, 1'b1, '1, '1, t + 257);
    tick(10);
    set_slot(2, 32'd8, 32'd2);
    bus.req_i = 4'b0110;
    push(2, 1'b0, 32'd4, 16'h0000, t + 264);
    wait_acks(1, 300);
    tick(1);
    bus.req_i = 4'b0100;
    dm_never = 1'b0;
    dm_lat = 4;
    chk("tmo_abort_count", 64'(n_abort - a0), 64'd1);
    chk("tmo_abort_cycle", 64'(abort_cyc), 64'(t + 256));
    wait_acks(1, 50);
    tick(1);
    bus.req_i = '0;
    chk("tmo_starts", 64'(n_start - s0), 64'd2);

    // Done coinciding with timeout cycle
    tick(2);
    set_slot(2, 32'd10, 32'd4);
    dm_lat = 255;
    a0 = n_abort;
    bus.req_i = 4'b0100;
    t = cyc;
    push(2, 1'b0, 32'd2, 16'h8000, t + 257);
    wait_acks(1, 300);
    tick(1);
    bus.req_i = '0;
    chk("coincide_no_abort", 64'(n_abort - a0), 64'd0);

    // Reset mid-WAIT with pointer at 3
    tick(2);
    set_slot(1, 32'd100, 32'd7);
    dm_lat = 50;
    bus.req_i = 4'b0010;
    tick(20);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",  64'(bus.busy_o), 64'd0);
    chk("midrst_ack",   64'(bus.ack_o), 64'd0);
    chk("midrst_err",   64'(bus.err_o), 64'd0);
    chk("midrst_q_int", 64'(bus.q_int_o), 64'd0);
    chk("midrst_q_dec", 64'(bus.q_dec_o), 64'd0);
    chk("midrst_div_a", 64'(bus.div_a_o), 64'd0);
    bus.req_i = '0;
    tick(2);
    rst_n = 1'b1;
    set_slot(0, 32'd100, 32'd7);
    set_slot(3, 32'd7, 32'd1);
    dm_lat = 4;
    bus.req_i = 4'b1001;
    t = cyc;
    push(0, 1'b0, 32'd14, 16'h4924, t + 6);
    push(3, 1'b0, 32'd7, 16'h0000, t + 13);
    wait_acks(2, 100);
    tick(1);
    bus.req_i = '0;

    tick(5);
    chk("queue_drained", 64'(expq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
